pc_fetch: RTL and testbench
===========================

# pc_fetch

Program-counter and fetch-control stage of the single-cycle processor, directly upstream of instruction decode. It holds the PC, drives the instruction-memory address, and computes the next PC: sequential, conditional branch, JAL, or JR. It also owns the run/halt state machine that freezes the PC once a HLT instruction is fetched. Decode receives `instr` and `pc` from this block; `pc_inc` is the JAL link value written back to R15.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `clk`  input  1: processor clock; all state updates on its rising edge.
- `rst`  input  1: synchronous, active-high reset.
- `instr`  input  16: instruction word returned by instruction memory for address `pc` (combinational, same cycle).
- `jr_data`  input  16: register-file read data for `instr[7:4]`, used as the JR target.
- `zr`, `neg`, `ov`  input  1 each: registered ALU flags (zero, negative, overflow).
- `stall`  input  1: hold the PC this cycle; nothing retires.
- `pc`  output  16: current PC; drives the instruction-memory address and the decode `PC` input.
- `pc_inc`  output  16: `pc + 1`, the JAL link value.
- `halted`  output  1: high while the FSM is in HALT.
- `instr_cnt`  output  16: retired-instruction count (see Configuration).

## Operation
- Word-addressed: the sequential next PC is `pc_inc = pc + 1`, 16-bit modulo, so 16'hFFFF wraps to 16'h0000.
- Opcode is `instr[15:12]`. Next-PC selection in RUN with `stall`=0:
  - 4'b1100 (B): condition is `instr[11:9]`: 000 NE (!zr), 001 EQ (zr), 010 GT (!zr & !neg), 011 LT (neg), 100 GTE (!neg), 101 LTE (neg | zr), 110 OVFL (ov), 111 UNCOND. If taken, next = `pc_inc + sext(instr[8:0])`; otherwise next = `pc_inc`.
  - 4'b1101 (JAL): next = `pc_inc + sext(instr[11:0])`.
  - 4'b1110 (JR): next = `jr_data`.
  - 4'b1111 (HLT): PC holds; FSM goes RUN -> HALT.
  - All other opcodes: next = `pc_inc`.
- Target arithmetic is 16-bit and sign-extended, and overflow is discarded (wrap).
- FSM states:
  - RUN: PC updates as above.
  - HALT: PC holds and `instr`, `stall`, and flags are ignored. Only `rst` leaves HALT.
- `stall`=1 in RUN: PC and FSM hold and nothing retires. If `stall`=1 while a HLT is presented, stall wins and the halt is taken on the first unstalled cycle.
- An instruction retires when the FSM is in RUN and `stall`=0. HLT counts as retired.
- Branch flags are sampled in the same cycle as the B instruction. Flag updates from that cycle's ALU result are not visible until the next cycle.

## Timing
- Reset values: `pc`=RESET_PC, `pc_inc`=RESET_PC+1, FSM=RUN, `halted`=0, `instr_cnt`=0.
- Reset is synchronous. `rst` at any clock edge, including in HALT or during a stall, forces the reset values on that edge and overrides all other inputs.
- Zero-latency fetch: `instr` for `pc` is valid in the same cycle, and the next PC is registered on the following rising edge.
- `halted` is registered. It rises on the edge that fetches HLT (one cycle after HLT appears on `instr`), and `pc` then stays at the HLT address.
- Taken branch, JAL, and JR take effect on the very next edge, with no delay slot and no bubble.
- `pc_inc` is combinational from `pc`.

## Configuration
- `PC_FETCH_PERF_CNT_EN` defined: `instr_cnt` is a 16-bit register that increments by 1 per retired instruction, wraps at 16'hFFFF -> 0, freezes in HALT, and clears on `rst`.
- Not defined: the counter is not built and `instr_cnt` is tied to 16'h0000.
- Next-PC behaviour is identical in both builds.

## Test plan
- Reset then three ADDs (16'h0123): `pc` steps 0 -> 1 -> 2 -> 3 on successive edges, and `halted`=0.
- B EQ, offset -2 (instr 16'hC3FE) at pc=5:
  - with zr=1: next pc=4.
  - with zr=0: next pc=6.
  - Repeat for all 8 conditions across flag combinations.
- JAL at pc=16'hFFFE with offset 12'h003: `pc_inc`=16'hFFFF and next pc=16'h0002 (wrap). JR with `jr_data`=16'h1234: next pc=16'h1234.
- HLT (16'hF000) at pc=7:
  - `halted`=1 after one edge and `pc` stays at 7 for 10 cycles regardless of inputs.
  - Asserting `rst` for one edge then gives pc=0 and `halted`=0.
- `stall`=1 for 3 cycles with HLT presented: `pc` holds and `halted` stays 0. After `stall` drops, `halted`=1 on the next edge.
- With `PC_FETCH_PERF_CNT_EN`: 5 instructions retired, 2 stall cycles, then HLT gives `instr_cnt`=6, frozen in HALT. Without the macro, `instr_cnt` stays 0 throughout.

Source files
------------

// File: rtl/pc_fetch.sv
// Program counter and fetch control: next-PC selection (seq/branch/JAL/JR) and run/halt FSM.
// Optional retired-instruction counter built when PC_FETCH_PERF_CNT_EN is defined.
module pc_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] instr_i,
  input  logic [15:0] jr_data_i,
  input  logic        zr_i,
  input  logic        neg_i,
  input  logic        ov_i,
  input  logic        stall_i,
  output logic [15:0] pc_o,
  output logic [15:0] pc_inc_o,
  output logic        halted_o,
  output logic [15:0] instr_cnt_o
);

  localparam logic [3:0] OpBranch = 4'b1100;
  localparam logic [3:0] OpJal    = 4'b1101;
  localparam logic [3:0] OpJr     = 4'b1110;
  localparam logic [3:0] OpHlt    = 4'b1111;

  typedef enum logic [0:0] {StRun, StHalt} state_e;

  state_e      state_q;
  logic [15:0] pc_q;
  logic [15:0] pc_d;
  logic        halted_q;
  logic        retire;
  logic        is_hlt;
  logic        br_taken;
  logic [15:0] br_off;
  logic [15:0] jal_off;

  assign pc_inc_o = pc_q + 16'd1;
  assign pc_o     = pc_q;
  assign halted_o = halted_q;

  assign retire = (state_q == StRun) && !stall_i;
  assign is_hlt = (instr_i[15:12] == OpHlt);
  assign br_off  = {{7{instr_i[8]}}, instr_i[8:0]};
  assign jal_off = {{4{instr_i[11]}}, instr_i[11:0]};

  always_comb begin
    br_taken = 1'b0;
    unique case (instr_i[11:9])
      3'b000:  br_taken = !zr_i;
      3'b001:  br_taken = zr_i;
      3'b010:  br_taken = !zr_i && !neg_i;
      3'b011:  br_taken = neg_i;
      3'b100:  br_taken = !neg_i;
      3'b101:  br_taken = neg_i || zr_i;
      3'b110:  br_taken = ov_i;
      default: br_taken = 1'b1;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (retire) begin
      unique case (instr_i[15:12])
        OpBranch: pc_d = br_taken ? (pc_inc_o + br_off) : pc_inc_o;
        OpJal:    pc_d = pc_inc_o + jal_off;
        OpJr:     pc_d = jr_data_i;
        OpHlt:    pc_d = pc_q;
        default:  pc_d = pc_inc_o;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= StRun;
      halted_q <= 1'b0;
      pc_q     <= RESET_PC;
    end else begin
      pc_q <= pc_d;
      case (state_q)
        StRun: begin
          if (!stall_i && is_hlt) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= StHalt;
          halted_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef PC_FETCH_PERF_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= 16'h0000;
    end else if (retire) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign instr_cnt_o = cnt_q;
`else
  assign instr_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_fetch.sv
// Self-checking bench for pc_fetch: directed scenarios plus randomized stimulus against
// an arithmetic reference model of the fetch rules.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic [15:0] jr_data;
  logic        zr, neg, ov, stall;
  logic [15:0] pc, pc_inc, instr_cnt;
  logic        halted;

  always #5 clk = ~clk;

  pc_fetch #(.RESET_PC(16'h0000)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .instr_i    (instr),
    .jr_data_i  (jr_data),
    .zr_i       (zr),
    .neg_i      (neg),
    .ov_i       (ov),
    .stall_i    (stall),
    .pc_o       (pc),
    .pc_inc_o   (pc_inc),
    .halted_o   (halted),
    .instr_cnt_o(instr_cnt)
  );

  int n_checks = 0;
  int n_errors = 0;

  int m_pc;
  bit m_halt;
  int m_cnt;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit cond_true(input int c, input bit z, input bit n, input bit o);
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return !n;
      5: return n || z;
      6: return o;
      default: return 1'b1;
    endcase
  endfunction

  function automatic int sext(input int v, input int bits);
    if (v >= (1 << (bits - 1))) return v - (1 << bits);
    return v;
  endfunction

  // Predict the state after the coming edge from the inputs currently applied.
  task automatic model_edge();
    int op;
    if (rst) begin
      m_pc = 0; m_halt = 0; m_cnt = 0;
    end else if (!m_halt && !stall) begin
      m_cnt = (m_cnt + 1) % 65536;
      op = int'(instr[15:12]);
      case (op)
        12: if (cond_true(int'(instr[11:9]), zr, neg, ov))
              m_pc = (m_pc + 1 + sext(int'(instr[8:0]), 9) + 65536) % 65536;
            else
              m_pc = (m_pc + 1) % 65536;
        13: m_pc = (m_pc + 1 + sext(int'(instr[11:0]), 12) + 65536) % 65536;
        14: m_pc = int'(jr_data);
        15: m_halt = 1;
        default: m_pc = (m_pc + 1) % 65536;
      endcase
    end
  endtask

  function automatic logic [15:0] exp_cnt();
`ifdef PC_FETCH_PERF_CNT_EN
    return 16'(m_cnt);
`else
    return 16'h0000;
`endif
  endfunction

  task automatic check_state(input string tag);
    check_eq({tag, ":pc"}, pc, 16'(m_pc));
    check_eq({tag, ":halted"}, {15'b0, halted}, {15'b0, m_halt});
    check_eq({tag, ":cnt"}, instr_cnt, exp_cnt());
  endtask

  task automatic cycle(input string tag);
    check_eq({tag, ":pc_inc"}, pc_inc, 16'((m_pc + 1) % 65536));
    model_edge();
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic drive(input logic [15:0] i, input logic s, input logic [15:0] jr,
                       input logic [2:0] flags, input logic r);
    instr = i; stall = s; jr_data = jr; {zr, neg, ov} = flags; rst = r;
  endtask

  task automatic jump_to(input logic [15:0] target);
    drive(16'hE000, 1'b0, target, 3'b000, 1'b0);
    cycle("jr_setup");
  endtask

  initial begin
    drive(16'h0123, 1'b0, 16'h0000, 3'b000, 1'b1);
    @(posedge clk);
    #1;
    m_pc = 0; m_halt = 0; m_cnt = 0;
    check_state("reset");
    check_eq("reset_pc_inc", pc_inc, 16'h0001);

    // Sequential ADDs
    drive(16'h0123, 1'b0, 16'h0000, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) cycle("seq");
    check_eq("seq_pc3", pc, 16'h0003);

    // BEQ -2 at pc=5
    jump_to(16'h0005);
    drive(16'hC3FE, 1'b0, 16'h0000, 3'b100, 1'b0);
    cycle("beq_taken");
    check_eq("beq_taken_pc", pc, 16'h0004);
    jump_to(16'h0005);
    drive(16'hC3FE, 1'b0, 16'h0000, 3'b000, 1'b0);
    cycle("beq_not");
    check_eq("beq_not_pc", pc, 16'h0006);

    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        jump_to(16'h0005);
        drive({4'hC, 3'(c), 9'h1FE}, 1'b0, 16'h0000, 3'(f), 1'b0);
        cycle("bcond");
      end
    end

    // JAL wrap, JR
    jump_to(16'hFFFE);
    check_eq("jal_pc_inc", pc_inc, 16'hFFFF);
    drive(16'hD003, 1'b0, 16'h0000, 3'b000, 1'b0);
    cycle("jal");
    check_eq("jal_wrap_pc", pc, 16'h0002);
    drive(16'hE0F0, 1'b0, 16'h1234, 3'b000, 1'b0);
    cycle("jr");
    check_eq("jr_pc", pc, 16'h1234);

    // HLT at 7, then random inputs while halted
    jump_to(16'h0007);
    drive(16'hF000, 1'b0, 16'h0000, 3'b000, 1'b0);
    cycle("hlt");
    check_eq("hlt_halted", {15'b0, halted}, 16'h0001);
    for (int i = 0; i < 10; i++) begin
      drive(16'($urandom), 1'($urandom), 16'($urandom), 3'($urandom), 1'b0);
      cycle("halt_hold");
    end
    check_eq("halt_pc", pc, 16'h0007);
    drive(16'h0123, 1'b0, 16'h0000, 3'b000, 1'b1);
    cycle("halt_rst");
    check_eq("halt_rst_pc", pc, 16'h0000);
    check_eq("halt_rst_halted", {15'b0, halted}, 16'h0000);

    // Stall with HLT presented
    drive(16'hF000, 1'b1, 16'h0000, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) cycle("stall_hlt");
    check_eq("stall_halted", {15'b0, halted}, 16'h0000);
    drive(16'hF000, 1'b0, 16'h0000, 3'b000, 1'b0);
    cycle("unstall_hlt");
    check_eq("unstall_halted", {15'b0, halted}, 16'h0001);

    // Counter: 5 retired, 2 stalls, HLT
    drive(16'h0123, 1'b0, 16'h0000, 3'b000, 1'b1);
    cycle("cnt_rst");
    drive(16'h0123, 1'b0, 16'h0000, 3'b000, 1'b0);
    for (int i = 0; i < 5; i++) cycle("cnt_run");
    drive(16'h0123, 1'b1, 16'h0000, 3'b000, 1'b0);
    for (int i = 0; i < 2; i++) cycle("cnt_stall");
    drive(16'hF000, 1'b0, 16'h0000, 3'b000, 1'b0);
    for (int i = 0; i < 4; i++) cycle("cnt_halt");
`ifdef PC_FETCH_PERF_CNT_EN
    check_eq("cnt_final", instr_cnt, 16'd6);
`else
    check_eq("cnt_final", instr_cnt, 16'd0);
`endif

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      drive(16'($urandom), ($urandom_range(0, 4) == 0), 16'($urandom), 3'($urandom),
            m_halt ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 40) == 0));
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
